// File: rtl/ysyx_25060173_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_25060173_ifu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StFault = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25060173_ifu_if.sv
// Instruction-memory valid/ready bus: request channel plus response channel.
interface ysyx_25060173_ifu_if;
  import ysyx_25060173_ifu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );

endinterface

// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction and
// hands it to the core; misaligned PCs and bus errors park it in a sticky fault.
module ysyx_25060173_ifu
  import ysyx_25060173_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] ResetPc = RESET_PC,
  parameter logic [XLEN-1:0] NopInst = NOP_INST
) (
  input  logic                       clk,
  input  logic                       reset,
  ysyx_25060173_ifu_if.master        imem_io,
  input  logic [XLEN-1:0]            next_pc_i,
  output logic [XLEN-1:0]            inst_o,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [XLEN-1:0]            now_pc_o,
  output logic                       fetch_fault_o,
  output logic [XLEN-1:0]            fault_pc_o
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic            pc_misaligned;

  assign pc_misaligned = |pc_q[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StBoot;
      pc_q       <= ResetPc;
      inst_q     <= NopInst;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    fault_pc_d = fault_pc_q;
    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        // A misaligned PC never reaches the bus.
        if (pc_misaligned) begin
          fault_pc_d = pc_q;
          state_d    = StFault;
        end else if (imem_io.req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_io.rsp_valid) begin
          if (imem_io.rsp_err) begin
            fault_pc_d = pc_q;
            state_d    = StFault;
          end else begin
            inst_d  = imem_io.rsp_data;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (inst_ready_i) begin
          pc_d    = next_pc_i;
          state_d = StReq;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  assign imem_io.req_valid = (state_q == StReq) && !pc_misaligned;
  assign imem_io.req_addr  = pc_q;
  assign imem_io.rsp_ready = (state_q == StWait);

  assign inst_valid_o  = (state_q == StHold);
  assign inst_o        = inst_valid_o ? inst_q : NopInst;
  assign now_pc_o      = pc_q;
  assign fetch_fault_o = (state_q == StFault);
  assign fault_pc_o    = fault_pc_q;

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Randomized bench for the fetch unit against a transaction-level reference model.
module tb_ysyx_25060173_ifu;
  import ysyx_25060173_ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] now_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  always #5 clk = ~clk;

  ysyx_25060173_ifu_if imem_if ();

  ysyx_25060173_ifu dut (
    .clk          (clk),
    .reset        (reset),
    .imem_io      (imem_if),
    .next_pc_i    (next_pc),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .now_pc_o     (now_pc),
    .fetch_fault_o(fetch_fault),
    .fault_pc_o   (fault_pc)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: what the fetch unit is currently doing.
  bit          m_boot, m_fault, m_pending, m_have;
  logic [31:0] m_pc, m_inst, m_fpc;

  // Memory model.
  bit          mem_busy, mem_err;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;

  // Stimulus knobs.
  int unsigned ready_pct, delay_max, err_pct, ir_pct, mis_pct, np_mode;
  logic [31:0] err_addr, np_fixed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return (a * 32'd2654435761) ^ 32'h5a5a_0003;
  endfunction

  task automatic check_outputs();
    bit req_exp;
    req_exp = !m_boot && !m_fault && !m_pending && !m_have && (m_pc[1:0] == 2'b00);
    check_eq("inst_valid", 32'(inst_valid), 32'(m_have));
    check_eq("inst", inst, m_have ? m_inst : NOP_INST);
    check_eq("req_valid", 32'(imem_if.req_valid), 32'(req_exp));
    check_eq("rsp_ready", 32'(imem_if.rsp_ready), 32'(m_pending));
    check_eq("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check_eq("fault_pc", fault_pc, m_fpc);
    if (m_have || m_boot) check_eq("now_pc", now_pc, m_pc);
    if (req_exp || m_boot) check_eq("req_addr", imem_if.req_addr, m_pc);
  endtask

  // One clock: check at the negedge, drive inputs, advance models, step to next negedge.
  task automatic cycle();
    logic [31:0] pick;
    int unsigned r;
    bit          req_hs, rsp_hs;
    check_outputs();
    imem_if.req_ready = ($urandom_range(99) < ready_pct);
    if (mem_busy && mem_cnt == 0) begin
      imem_if.rsp_valid = 1'b1;
      imem_if.rsp_data  = mem_word(mem_addr);
      imem_if.rsp_err   = mem_err;
    end else begin
      imem_if.rsp_valid = 1'b0;
      imem_if.rsp_data  = $urandom;
      imem_if.rsp_err   = 1'($urandom_range(1));
    end
    inst_ready = ($urandom_range(99) < ir_pct);
    r = $urandom_range(99);
    if (np_mode == 1) pick = np_fixed;
    else if (np_mode == 0) pick = m_pc + 32'd4;
    else if (r < mis_pct) pick = m_pc + 32'd4 + 32'($urandom_range(1, 3));
    else if (r < mis_pct + 5) pick = 32'hFFFF_FFFC;
    else if (r < mis_pct + 25) pick = $urandom & 32'hFFFF_FFFC;
    else pick = m_pc + 32'd4;
    next_pc = pick;

    req_hs = imem_if.req_valid && imem_if.req_ready;
    rsp_hs = imem_if.rsp_valid && imem_if.rsp_ready;

    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (m_have) begin
      if (inst_ready) begin
        m_pc   = pick;
        m_have = 1'b0;
      end
    end else if (m_pending) begin
      if (imem_if.rsp_valid) begin
        m_pending = 1'b0;
        if (imem_if.rsp_err) begin
          m_fault = 1'b1;
          m_fpc   = m_pc;
        end else begin
          m_inst = imem_if.rsp_data;
          m_have = 1'b1;
        end
      end
    end else if (m_pc[1:0] != 2'b00) begin
      m_fault = 1'b1;
      m_fpc   = m_pc;
    end else if (imem_if.req_ready) begin
      m_pending = 1'b1;
    end

    if (mem_busy) begin
      if (rsp_hs) mem_busy = 1'b0;
      else if (mem_cnt > 0) mem_cnt--;
    end else if (req_hs) begin
      mem_busy = 1'b1;
      mem_addr = imem_if.req_addr;
      mem_cnt  = $urandom_range(delay_max);
      mem_err  = (imem_if.req_addr == err_addr) || ($urandom_range(99) < err_pct);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset asynchronously and checks the cleared outputs.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, NOP_INST);
    check_eq("rst_now_pc", now_pc, RESET_PC);
    check_eq("rst_req_valid", 32'(imem_if.req_valid), 32'd0);
    check_eq("rst_req_addr", imem_if.req_addr, RESET_PC);
    check_eq("rst_rsp_ready", 32'(imem_if.rsp_ready), 32'd0);
    check_eq("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    check_eq("rst_fault_pc", fault_pc, 32'd0);
    imem_if.req_ready = 1'b0;
    imem_if.rsp_valid = 1'b0;
    imem_if.rsp_err   = 1'b0;
    imem_if.rsp_data  = '0;
    inst_ready        = 1'b0;
    m_boot = 1'b1; m_fault = 1'b0; m_pending = 1'b0; m_have = 1'b0;
    m_pc = RESET_PC; m_fpc = '0; m_inst = NOP_INST;
    mem_busy = 1'b0; mem_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_knobs(input int unsigned rdy, input int unsigned dly, input int unsigned ir,
                           input int unsigned npm);
    ready_pct = rdy; delay_max = dly; ir_pct = ir; np_mode = npm;
    err_pct = 0; mis_pct = 0; err_addr = 32'h1; np_fixed = 32'h8000_0004;
  endtask

  initial begin
    int unsigned guard;
    reset = 1'b0;
    next_pc = '0;
    inst_ready = 1'b0;
    imem_if.req_ready = 1'b0;
    imem_if.rsp_valid = 1'b0;
    imem_if.rsp_data  = '0;
    imem_if.rsp_err   = 1'b0;
    set_knobs(100, 0, 100, 1);
    @(negedge clk);

    // Zero-wait fetch from reset.
    do_reset();
    cycle();
    check_eq("t1_req_valid", 32'(imem_if.req_valid), 32'd1);
    check_eq("t1_req_addr", imem_if.req_addr, 32'h8000_0000);
    cycle();
    cycle();
    check_eq("t1_inst_valid", 32'(inst_valid), 32'd1);
    check_eq("t1_inst", inst, 32'h0010_0093);
    check_eq("t1_now_pc", now_pc, 32'h8000_0000);
    cycle();
    check_eq("t1_next_req", 32'(imem_if.req_valid), 32'd1);
    check_eq("t1_next_addr", imem_if.req_addr, 32'h8000_0004);

    // Memory stalls the request.
    ready_pct = 0;
    repeat (4) begin
      cycle();
      check_eq("t2_req_held", 32'(imem_if.req_valid), 32'd1);
      check_eq("t2_addr_held", imem_if.req_addr, 32'h8000_0004);
      check_eq("t2_no_wait", 32'(imem_if.rsp_ready), 32'd0);
    end
    ready_pct = 100;
    cycle();
    check_eq("t2_wait", 32'(imem_if.rsp_ready), 32'd1);

    // Core stalls in HOLD.
    ir_pct = 0;
    cycle();
    repeat (5) begin
      cycle();
      check_eq("t3_inst", inst, mem_word(32'h8000_0004));
      check_eq("t3_now_pc", now_pc, 32'h8000_0004);
      check_eq("t3_no_req", 32'(imem_if.req_valid), 32'd0);
      check_eq("t3_no_rsp_ready", 32'(imem_if.rsp_ready), 32'd0);
    end

    // Misaligned next_pc faults on the following REQ.
    ir_pct = 100; np_fixed = 32'h8000_0102;
    cycle();
    check_eq("t4_no_req", 32'(imem_if.req_valid), 32'd0);
    cycle();
    repeat (5) begin
      check_eq("t4_fault", 32'(fetch_fault), 32'd1);
      check_eq("t4_fault_pc", fault_pc, 32'h8000_0102);
      check_eq("t4_silent", 32'(imem_if.req_valid), 32'd0);
      cycle();
    end

    // Bus error on the third fetch.
    do_reset();
    set_knobs(100, 0, 100, 0);
    err_addr = 32'h8000_0008;
    guard = 0;
    while (!m_fault && guard < 40) begin
      check_eq("t5_no_inst", 32'(inst_valid && now_pc == 32'h8000_0008), 32'd0);
      cycle();
      guard++;
    end
    check_eq("t5_fault", 32'(fetch_fault), 32'd1);
    check_eq("t5_fault_pc", fault_pc, 32'h8000_0008);

    // Reset while waiting for a response.
    do_reset();
    set_knobs(100, 3, 100, 0);
    cycle();
    cycle();
    check_eq("t6_in_wait", 32'(imem_if.rsp_ready), 32'd1);
    do_reset();
    cycle();
    check_eq("t6_boot_to_req", 32'(imem_if.req_valid), 32'd1);
    check_eq("t6_req_addr", imem_if.req_addr, 32'h8000_0000);

    // Random episodes.
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      set_knobs($urandom_range(30, 100), $urandom_range(3), $urandom_range(20, 100), 2);
      err_pct = (ep % 3 == 2) ? 2 : 0;
      mis_pct = (ep % 4 == 3) ? 2 : 0;
      repeat (300) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_25060173_ifu.md
Name: ysyx_25060173_ifu

Overview:
- Instruction fetch unit directly upstream of the single-cycle core.
- Owns the architectural PC and issues one word fetch per instruction over a valid/ready instruction-memory bus.
- Presents the fetched word to the core with a valid/ready handshake, and takes the core's computed next_pc when the core accepts.
- Traps misaligned fetch addresses and bus errors as a sticky fault.

Parameters:
- RESET_PC, 32'h80000000, PC loaded at reset.
- NOP_INST, 32'h00000013, value driven on inst whenever inst_valid=0.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- reset  in  1  Asynchronous, active-low reset: reset=0 clears all state immediately, and release is synchronous to clk.
- next_pc  in  32  Core's computed successor PC; sampled only on an inst handshake.
- inst  out  32  Fetched instruction to the core.
- inst_valid  out  1  inst and now_pc are valid.
- inst_ready  in  1  Core accepts inst this cycle (instruction commit).
- now_pc  out  32  PC of the instruction on inst.
- imem_req_valid  out  1  Fetch request valid.
- imem_req_ready  in  1  Memory accepts the request.
- imem_req_addr  out  32  Fetch address, word aligned.
- imem_rsp_valid  in  1  Response valid.
- imem_rsp_ready  out  1  IFU can take a response.
- imem_rsp_data  in  32  Response word.
- imem_rsp_err  in  1  Response carries a bus error.
- fetch_fault  out  1  Sticky fault flag.
- fault_pc  out  32  PC that faulted.

Behaviour:
- Reset values (reset=0):
  - pc=RESET_PC and state=BOOT.
  - inst=NOP_INST, inst_valid=0, now_pc=RESET_PC.
  - imem_req_valid=0, imem_req_addr=RESET_PC, imem_rsp_ready=0.
  - fetch_fault=0, fault_pc=0.
- State machine: BOOT, REQ, WAIT, HOLD, FAULT.
- BOOT: unconditional to REQ one cycle after reset release, giving the core one settle cycle.
- REQ:
  - If pc[1:0]!=0: imem_req_valid stays 0, latch fault_pc=pc, go to FAULT.
  - Otherwise: imem_req_valid=1, imem_req_addr=pc.
  - Go to WAIT on imem_req_valid & imem_req_ready.
  - Address and valid are held stable while ready=0; the request is never withdrawn.
- WAIT:
  - imem_rsp_ready=1.
  - On imem_rsp_valid & imem_rsp_err: latch fault_pc=pc, go to FAULT.
  - On imem_rsp_valid & !imem_rsp_err: register inst=imem_rsp_data, go to HOLD.
- HOLD:
  - inst_valid=1, now_pc=pc; inst is held stable until accepted.
  - On inst_ready: pc<=next_pc, inst_valid drops next cycle, go to REQ.
- FAULT:
  - fetch_fault=1 and all handshake outputs 0.
  - Stays in FAULT until reset; no further requests.
- Handshake rules:
  - imem_rsp_ready=0 outside WAIT; responses arriving then are not consumed.
  - At most one request is outstanding.
  - inst_valid=0 in every state except HOLD, and inst=NOP_INST whenever inst_valid=0.
- Latency:
  - Zero-wait memory (req_ready=1, rsp_valid the cycle after acceptance) gives REQ→WAIT→HOLD, so inst_valid rises 2 cycles after REQ entry.
  - Throughput is 3 cycles per instruction when inst_ready=1.
- Boundaries:
  - pc wraps modulo 2^32; no special handling at 32'hFFFFFFFC.
  - A misaligned next_pc is accepted into pc and faults on the following REQ cycle.
  - Reset asserted mid-request or mid-response discards all in-flight state; instruction memory shares the same reset, so no stale response follows.
  - inst_ready while inst_valid=0 has no effect.

Decomposition:
- Shared package holds:
  - the state encoding (3-bit localparams BOOT/REQ/WAIT/HOLD/FAULT);
  - RESET_PC and NOP_INST defaults;
  - the 32-bit XLEN constant, shared with core and register file.
- Single module; no sub-module is warranted.

Test Plan:
- Release reset, zero-wait memory returning 32'h00100093 at 0x80000000, inst_ready=1, next_pc=0x80000004 → imem_req_addr=0x80000000, inst_valid high 2 cycles after REQ, now_pc=0x80000000, next request addr=0x80000004.
- Hold imem_req_ready=0 for 4 cycles → imem_req_valid stays 1 and addr unchanged; WAIT entered only on the ready cycle.
- Core holds inst_ready=0 for 5 cycles in HOLD → inst and now_pc stable, no new request issued, imem_rsp_ready=0.
- Accept with next_pc=0x80000102 → next cycle REQ issues no request, fetch_fault=1, fault_pc=0x80000102, and fault persists until reset.
- Response with imem_rsp_err=1 at pc 0x80000008 → fetch_fault=1, fault_pc=0x80000008, inst_valid never asserted.
- Assert reset=0 while in WAIT → outputs return to reset values in the same cycle (asynchronous); after release, BOOT then REQ at 0x80000000.
